// File: rtl/servo_pwm_frame_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pwm_frame_gen_pkg
//  Description : Shared FSM encoding, default timing constants and clog2 helper
//                for the servo PWM frame generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package servo_pwm_frame_gen_pkg;

    localparam int          DEF_CLK_HZ    = 50_000_000;
    localparam int          DEF_FRAME_US  = 20000;
    localparam int          DEF_MIN_US    = 1000;
    localparam int          DEF_MAX_US    = 2000;
    localparam logic [7:0]  DEF_RESET_POS = 8'd128;
    localparam int          POS_W         = 8;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } servo_state_t;

    // Never returns 0 so it can size a counter for any value >= 1.
    function automatic int servo_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pwm_frame_gen_us_tick.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pwm_frame_gen_us_tick
//  Description : Microsecond prescaler with synchronous clear; emits a
//                one-clock tick at the terminal count.
//  Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_frame_gen_us_tick
    import servo_pwm_frame_gen_pkg::*;
#(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic us_tick
);

    localparam int CNT_W = servo_clog2(DIV);

    logic [CNT_W-1:0] r_cnt;
    logic             w_terminal;

    assign w_terminal = (r_cnt == CNT_W'(DIV - 1));
    assign us_tick    = w_terminal && !clear;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (w_terminal) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/servo_pwm_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pwm_frame_gen
//  Description : Hobby-servo PWM generator; one pulse per frame, width linear in
//                an 8-bit position taken over valid/ready, applied at frame starts.
//  Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_frame_gen
    import servo_pwm_frame_gen_pkg::*;
#(
    parameter int         CLK_HZ    = DEF_CLK_HZ,
    parameter int         FRAME_US  = DEF_FRAME_US,
    parameter int         MIN_US    = DEF_MIN_US,
    parameter int         MAX_US    = DEF_MAX_US,
    parameter logic [7:0] RESET_POS = DEF_RESET_POS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [POS_W-1:0] pos_data,
    input  logic             pos_valid,
    output logic             pos_ready,
    output logic             pwm_out,
    output logic             frame_start,
    output logic [POS_W-1:0] active_pos
);

    localparam int DIV    = CLK_HZ / 1_000_000;
    localparam int SPAN   = MAX_US - MIN_US;
    localparam int US_W   = servo_clog2(FRAME_US);
    localparam int PROD_W = POS_W + servo_clog2(SPAN + 1);

    servo_state_t     r_state;
    logic [US_W-1:0]  r_us_cnt;
    logic [US_W-1:0]  r_width;
    logic [POS_W-1:0] r_active;
    logic [POS_W-1:0] r_pending;
    logic             r_pending_full;
    logic             r_pwm;
    logic             r_frame_start;

    logic             w_us_tick;
    logic             w_tick_clear;
    logic             w_frame_end;
    logic             w_boundary;
    logic             w_accept;
    logic [POS_W-1:0] w_next_active;

    // Truncating scale: position 256 would reach MAX_US, 255 stays just short.
    function automatic logic [US_W-1:0] calc_width(input logic [POS_W-1:0] pos);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(pos) * PROD_W'(SPAN);
        return US_W'(MIN_US) + US_W'(prod >> POS_W);
    endfunction

    servo_pwm_frame_gen_us_tick #(
        .DIV (DIV)
    ) u_us_tick (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_tick_clear),
        .us_tick (w_us_tick)
    );

    // Prescaler is held at zero whenever the frame is not running, so every
    // fresh frame begins on a whole microsecond.
    assign w_tick_clear  = !en || (r_state == S_OFF);
    assign w_frame_end   = w_us_tick && (r_us_cnt == US_W'(FRAME_US - 1));
    assign w_boundary    = en && ((r_state == S_OFF) || w_frame_end);
    assign w_accept      = pos_valid && !r_pending_full;
    assign w_next_active = r_pending_full ? r_pending : r_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_OFF;
            r_us_cnt       <= '0;
            r_width        <= calc_width(RESET_POS);
            r_active       <= RESET_POS;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_pwm          <= 1'b0;
            r_frame_start  <= 1'b0;
        end else begin
            r_frame_start <= w_boundary;
            r_pwm         <= en && (r_state == S_PULSE);

            if (w_boundary) begin
                r_active       <= w_next_active;
                r_width        <= calc_width(w_next_active);
                r_pending_full <= 1'b0;
            end

            // Accept is only possible with the buffer empty, so it never
            // races a transfer; a boundary-cycle word lands in pending.
            if (w_accept) begin
                r_pending      <= pos_data;
                r_pending_full <= 1'b1;
            end

            if (!en) begin
                r_state  <= S_OFF;
                r_us_cnt <= '0;
            end else if (w_boundary) begin
                r_state  <= S_PULSE;
                r_us_cnt <= '0;
            end else if (w_us_tick) begin
                r_us_cnt <= r_us_cnt + US_W'(1);
                if ((r_state == S_PULSE) && (r_us_cnt == r_width - US_W'(1))) begin
                    r_state <= S_GAP;
                end
            end
        end
    end

    assign pos_ready   = !r_pending_full;
    assign pwm_out     = r_pwm;
    assign frame_start = r_frame_start;
    assign active_pos  = r_active;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servo_pwm_frame_gen
//  Description : Directed plus randomized bench for servo_pwm_frame_gen against
//                a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_frame_gen;

    localparam int CLK_HZ     = 4_000_000;
    localparam int FRAME_US   = 200;
    localparam int MIN_US     = 10;
    localparam int MAX_US     = 20;
    localparam int CPU        = CLK_HZ / 1_000_000;
    localparam int FRAME_CLKS = FRAME_US * CPU;
    localparam int BOUND      = 4000;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       en        = 1'b0;
    logic [7:0] pos_data  = 8'd0;
    logic       pos_valid = 1'b0;
    logic       pos_ready;
    logic       pwm_out;
    logic       frame_start;
    logic [7:0] active_pos;

    always #5 clk = ~clk;

    servo_pwm_frame_gen #(
        .CLK_HZ    (CLK_HZ),
        .FRAME_US  (FRAME_US),
        .MIN_US    (MIN_US),
        .MAX_US    (MAX_US),
        .RESET_POS (8'd128)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pos_data    (pos_data),
        .pos_valid   (pos_valid),
        .pos_ready   (pos_ready),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .active_pos  (active_pos)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cycle  = 0;

    // Reference model: frame phase in clocks since frame_start, active/pending words.
    bit m_run    = 1'b0;
    int m_phase  = 0;
    int m_active = 128;
    int m_pend   = 0;
    bit m_full   = 1'b0;
    int m_w      = 0;
    bit m_acc    = 1'b0;
    bit m_pwm    = 1'b0;
    bit m_fs     = 1'b0;

    int obs_len   = 0;
    int obs_hi    = 0;
    int saved_w   = 0;
    bit clean     = 1'b0;
    bit have_prev = 1'b0;

    function automatic int exp_width_clks(input int pos);
        return CPU * (MIN_US + (pos * (MAX_US - MIN_US)) / 256);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d at cycle %0d", tag, obs, exp, cycle);
        end
    endtask

    task automatic cyc();
        bit acc_ok;
        acc_ok = pos_valid && !m_full && !rst;
        m_acc  = 1'b0;
        m_fs   = 1'b0;
        m_pwm  = 1'b0;
        if (rst) begin
            m_run    = 1'b0;
            m_active = 128;
            m_full   = 1'b0;
        end else begin
            if (en) begin
                if (!m_run || m_phase == FRAME_CLKS - 1) begin
                    m_run   = 1'b1;
                    m_phase = 0;
                    if (m_full) begin
                        m_active = m_pend;
                        m_full   = 1'b0;
                    end
                    m_w  = exp_width_clks(m_active);
                    m_fs = 1'b1;
                end else begin
                    m_phase++;
                end
                m_pwm = (m_phase >= 1) && (m_phase <= m_w);
            end else begin
                m_run = 1'b0;
            end
            if (acc_ok) begin
                m_pend = pos_data;
                m_full = 1'b1;
                m_acc  = 1'b1;
            end
        end

        @(posedge clk);
        @(negedge clk);
        cycle++;

        chk("pwm_out", pwm_out, m_pwm);
        chk("frame_start", frame_start, m_fs);
        chk("active_pos", active_pos, m_active);
        chk("pos_ready", pos_ready, !m_full);

        // Whole-frame view: pulse length and frame spacing of uninterrupted frames.
        if (rst || !en) clean = 1'b0;
        if (frame_start === 1'b1) begin
            if (clean && have_prev) begin
                chk("frame_len", obs_len, FRAME_CLKS - 1);
                chk("pulse_clks", obs_hi, saved_w);
            end
            have_prev = 1'b1;
            clean     = 1'b1;
            saved_w   = exp_width_clks(m_active);
            obs_len   = 0;
            obs_hi    = 0;
        end else begin
            obs_len++;
            if (pwm_out === 1'b1) obs_hi++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic run_until_phase(input int p);
        int k;
        k = 0;
        while (!(m_run && m_phase == p) && k < BOUND) begin
            cyc();
            k++;
        end
        n_cmp++;
        assert (k < BOUND) else begin
            n_fail++;
            $error("FAIL phase_wait: waited %0d cycles, required under %0d", k, BOUND);
        end
    endtask

    task automatic offer(input logic [7:0] d);
        int k;
        pos_data  = d;
        pos_valid = 1'b1;
        k = 0;
        m_acc = 1'b0;
        while (!m_acc && k < BOUND) begin
            cyc();
            k++;
        end
        pos_valid = 1'b0;
    endtask

    initial begin
        // Reset state, then free running at the centre position
        run(3);
        rst = 1'b0;
        run(2);
        en = 1'b1;
        run(2 * FRAME_CLKS + 5);

        // Extremes, each accepted mid-frame
        run_until_phase(300);
        offer(8'd0);
        run_until_phase(300);
        offer(8'd255);
        run_until_phase(300);
        run(FRAME_CLKS + 100);

        // Back-to-back words: second is held off until the first is consumed
        run_until_phase(100);
        offer(8'h10);
        offer(8'h20);
        run(2 * FRAME_CLKS + 100);

        // Enable dropped mid-pulse, then restored
        run_until_phase(30);
        en = 1'b0;
        run(100);
        en = 1'b1;
        run(2 * FRAME_CLKS + 100);

        // Reset during a pulse with 0xFF pending
        run_until_phase(100);
        offer(8'h40);
        run_until_phase(5);
        offer(8'hFF);
        run_until_phase(20);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(2 * FRAME_CLKS + 100);

        // Word accepted on the frame-boundary edge
        run_until_phase(FRAME_CLKS - 1);
        offer(8'hC8);
        run(2 * FRAME_CLKS + 100);

        for (int it = 0; it < 16; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                run(int'($urandom_range(1, 900)));
                offer(8'($urandom_range(0, 255)));
            end else if (r < 8) begin
                run(int'($urandom_range(1, 700)));
                en = 1'b0;
                run(int'($urandom_range(1, 60)));
                en = 1'b1;
            end else begin
                run(int'($urandom_range(1, 700)));
                rst = 1'b1;
                run(int'($urandom_range(1, 3)));
                rst = 1'b0;
            end
        end
        run(2 * FRAME_CLKS + 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
